card_fetch_scheduler: RTL and testbench

- Sequences per-frame reads of the ten card-slot words from processor data memory (RAM[16..25]) through a shared read port using a req/gnt handshake.
- Holds the fetched values in a double-buffered slot table, so the VGA renderer gets a stable per-slot card index and win/loss state for a whole frame.
- Sits between the CPU memory arbiter and the VGA controller. Fetching is triggered by the timing generator's screenEnd pulse.

---
 rtl/card_fetch_scheduler.sv | 158 +++++++++++++++
 tb/tb_card_fetch_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_fetch_scheduler.sv
// rtl/card_fetch_scheduler.sv - per-frame card slot fetcher with double-buffered slot table
module card_fetch_scheduler #(
    parameter int NUM_SLOTS = 10,
    parameter int BASE_ADDR = 16,
    parameter int NUM_CARDS = 14,
    parameter int IDX_WIDTH = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    output logic                 mem_req,
    input  logic                 mem_gnt,
    output logic [31:0]          mem_addr,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_rvalid,
    input  logic [1:0]           win_loss_in,
    input  logic [3:0]           slot_sel,
    output logic [IDX_WIDTH-1:0] card_index,
    output logic                 slot_valid,
    output logic [1:0]           win_loss,
    output logic                 busy,
    output logic                 frame_miss,
    output logic                 fetch_err
);
    localparam int              WD_W      = $clog2(TIMEOUT + 1);
    localparam logic [3:0]      LAST_SLOT = 4'(NUM_SLOTS - 1);
    localparam logic [WD_W-1:0] WD_LIMIT  = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_DATA, S_COMMIT} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             slot_q, slot_d;
    logic [WD_W-1:0]        wdog_q, wdog_d;
    logic                   frame_miss_q, fetch_err_q;
    logic [IDX_WIDTH-1:0]   card_index_q;
    logic                   slot_valid_q;
    logic [1:0]             win_loss_q;
    logic                   shadow_we, commit, abort;

    // Shadow bank fills during the fetch; display bank only changes on commit.
    logic [IDX_WIDTH-1:0]   shadow_idx_q  [NUM_SLOTS];
    logic [IDX_WIDTH-1:0]   display_idx_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]   shadow_vld_q, display_vld_q;

    logic [IDX_WIDTH-1:0]   rd_idx;
    logic                   rd_vld;

    assign rd_idx = mem_rdata[IDX_WIDTH-1:0];
    assign rd_vld = !mem_rdata[31] && (32'(rd_idx) < 32'(NUM_CARDS));

    assign mem_req    = (state_q == S_REQ);
    assign mem_addr   = 32'(BASE_ADDR) + {28'b0, slot_q};
    assign busy       = (state_q != S_IDLE);
    assign frame_miss = frame_miss_q;
    assign fetch_err  = fetch_err_q;
    assign card_index = card_index_q;
    assign slot_valid = slot_valid_q;
    assign win_loss   = win_loss_q;

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        wdog_d    = wdog_q;
        shadow_we = 1'b0;
        commit    = 1'b0;
        abort     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    slot_d  = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    wdog_d  = '0;
                    state_d = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (mem_rvalid) begin
                    shadow_we = 1'b1;
                    if (slot_q == LAST_SLOT) begin
                        state_d = S_COMMIT;
                    end else begin
                        slot_d  = slot_q + 4'd1;
                        state_d = S_REQ;
                    end
                end else if (wdog_q == WD_LIMIT) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            S_COMMIT: begin
                commit  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            slot_q       <= '0;
            wdog_q       <= '0;
            frame_miss_q <= 1'b0;
            fetch_err_q  <= 1'b0;
            win_loss_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            wdog_q       <= wdog_d;
            frame_miss_q <= frame_start && (state_q != S_IDLE);
            fetch_err_q  <= abort;
            if (commit) begin
                win_loss_q <= win_loss_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_vld_q  <= '0;
            display_vld_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                shadow_idx_q[i]  <= '0;
                display_idx_q[i] <= '0;
            end
        end else begin
            if (shadow_we) begin
                shadow_idx_q[slot_q] <= rd_idx;
                shadow_vld_q[slot_q] <= rd_vld;
            end
            if (commit) begin
                display_idx_q <= shadow_idx_q;
                display_vld_q <= shadow_vld_q;
            end
        end
    end

    // A lookup coincident with commit still sees the old bank.
    always_ff @(posedge clk) begin
        if (!reset) begin
            card_index_q <= '0;
            slot_valid_q <= 1'b0;
        end else if (slot_sel <= LAST_SLOT) begin
            card_index_q <= display_idx_q[slot_sel];
            slot_valid_q <= display_vld_q[slot_sel];
        end else begin
            card_index_q <= '0;
            slot_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_card_fetch_scheduler.sv
// tb/tb_card_fetch_scheduler.sv - scoreboard bench for card_fetch_scheduler
module tb_card_fetch_scheduler;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset, frame_start, mem_req, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_rdata;
    logic [1:0]  win_loss_in, win_loss;
    logic [3:0]  slot_sel, card_index;
    logic        slot_valid, busy, frame_miss, fetch_err;

    card_fetch_scheduler dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .win_loss_in(win_loss_in), .slot_sel(slot_sel),
        .card_index(card_index), .slot_valid(slot_valid), .win_loss(win_loss),
        .busy(busy), .frame_miss(frame_miss), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] ci;
        logic       sv;
        logic [1:0] wl;
        logic       busy;
        logic       miss;
        logic       err;
        logic       req;
        logic       chk_addr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];

    // Reference model: a fetch is a list of ten (grant, data) transactions, then a bank swap.
    bit         m_active = 0, m_granted = 0, m_commit = 0;
    int         m_nxt = 0, m_wait = 0;
    logic [3:0] m_disp_idx[10], m_sh_idx[10];
    bit         m_disp_vld[10], m_sh_vld[10];
    logic [1:0] m_wl = 2'b00;

    // Arbiter knobs
    int          gnt_stall[10];
    logic [31:0] data_tbl[10];
    int          drop_slot = -1;
    bit          rand_mode = 0;
    bit          spur_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return {1'b0, 27'($urandom), 4'($urandom_range(0, 13))};
            1:       return {1'b0, 27'($urandom), 4'($urandom_range(14, 15))};
            2:       return {1'b1, 27'($urandom), 4'($urandom_range(0, 13))};
            default: return $urandom;
        endcase
    endfunction

    // Arbiter / memory responder
    initial begin
        bit          pend, in_req, drop;
        int          stall, rvw, s;
        logic [31:0] cur;
        pend = 0; in_req = 0; drop = 0; stall = 0; rvw = 0; cur = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        forever begin
            @(negedge clk); #1;
            mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
            if (!reset) begin
                pend = 0; in_req = 0;
            end else begin
                if (pend && drop && mem_req === 1'b1) pend = 0;
                if (pend) begin
                    if (rvw > 0) rvw--;
                    else if (!drop) begin
                        mem_rvalid = 1; mem_rdata = cur; pend = 0;
                    end
                end else if (mem_req === 1'b1) begin
                    s = int'(mem_addr) - 16;
                    if (s < 0 || s > 9) s = 0;
                    if (!in_req) begin
                        in_req = 1; stall = gnt_stall[s];
                    end
                    if (stall > 0) begin
                        stall--;
                        if (spur_en && $urandom_range(0, 2) == 0) mem_rvalid = 1;
                    end else begin
                        mem_gnt = 1; in_req = 0; pend = 1; cur = data_tbl[s];
                        drop = (s == drop_slot);
                        rvw = rand_mode ? int'($urandom_range(0, 3)) : 0;
                    end
                end
            end
        end
    end

    // Predictor: computes what the next clock edge should produce
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #3;
            e.ci = (slot_sel < 10) ? m_disp_idx[slot_sel] : 4'd0;
            e.sv = (slot_sel < 10) ? m_disp_vld[slot_sel] : 1'b0;
            e.miss = 0; e.err = 0; e.chk_addr = 0;
            if (!reset) begin
                m_active = 0; m_granted = 0; m_commit = 0; m_wl = 2'b00;
                for (int i = 0; i < 10; i++) begin
                    m_disp_idx[i] = 0; m_disp_vld[i] = 0; m_sh_idx[i] = 0; m_sh_vld[i] = 0;
                end
                e.ci = 0; e.sv = 0; e.chk_addr = 1;
                addr_q.delete();
            end else begin
                e.miss = frame_start && m_active;
                if (!m_active) begin
                    if (frame_start) begin
                        m_active = 1; m_nxt = 0; m_granted = 0;
                        addr_q.push_back(32'd16);
                    end
                end else if (m_commit) begin
                    for (int i = 0; i < 10; i++) begin
                        m_disp_idx[i] = m_sh_idx[i]; m_disp_vld[i] = m_sh_vld[i];
                    end
                    m_wl = win_loss_in; m_active = 0; m_commit = 0;
                end else if (!m_granted) begin
                    if (mem_gnt) begin
                        m_granted = 1; m_wait = 0;
                    end
                end else if (mem_rvalid) begin
                    m_sh_idx[m_nxt] = mem_rdata[3:0];
                    m_sh_vld[m_nxt] = !mem_rdata[31] && (mem_rdata[3:0] < 14);
                    m_granted = 0;
                    if (m_nxt == 9) m_commit = 1;
                    else begin
                        m_nxt++;
                        addr_q.push_back(32'(16 + m_nxt));
                    end
                end else begin
                    m_wait++;
                    if (m_wait == TIMEOUT) begin
                        e.err = 1; m_active = 0;
                    end
                end
            end
            e.wl = m_wl; e.busy = m_active; e.req = m_active && !m_granted && !m_commit;
            exp_q.push_back(e);
        end
    end

    // Monitor: pops expectations and compares DUT outputs
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("card_index", 32'(card_index), 32'(e.ci));
                check("slot_valid", 32'(slot_valid), 32'(e.sv));
                check("win_loss",   32'(win_loss),   32'(e.wl));
                check("busy",       32'(busy),       32'(e.busy));
                check("frame_miss", 32'(frame_miss), 32'(e.miss));
                check("fetch_err",  32'(fetch_err),  32'(e.err));
                check("mem_req",    32'(mem_req),    32'(e.req));
                if (e.chk_addr) check("reset_addr", mem_addr, 32'd16);
            end
            if (mem_req === 1'b1 && addr_q.size() > 0) check("mem_addr", mem_addr, addr_q[0]);
            if (mem_req === 1'b1 && mem_gnt === 1'b1) begin
                if (addr_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL grant_unexpected: addr %0h granted, none expected", mem_addr);
                end else begin
                    void'(addr_q.pop_front());
                end
            end
        end
    end

    task automatic start_frame();
        @(negedge clk); frame_start = 1;
        @(negedge clk); frame_start = 0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (m_active && n < lim) begin
            @(negedge clk); n++;
        end
        if (m_active) begin
            tests++; fails++;
            $display("FAIL wait_idle: still fetching after %0d cycles, required idle", n);
        end
    endtask

    task automatic sweep();
        for (int s = 0; s < 16; s++) begin
            @(negedge clk); slot_sel = 4'(s);
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        reset = 0; frame_start = 0; slot_sel = 0; win_loss_in = 0;
        for (int i = 0; i < 10; i++) begin
            gnt_stall[i] = 0; data_tbl[i] = 32'(i);
        end
        repeat (3) @(negedge clk);
        reset = 1;

        // Immediate grants, data = slot number; 21-cycle fetch
        win_loss_in = 2'b10;
        start_frame();
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++; @(negedge clk);
        end
        check("fetch_cycles", 32'(n), 32'd21);
        sweep();

        // Invalid entries: bit31 set and index out of range
        win_loss_in = 2'b00;
        data_tbl[2] = 32'h8000_0005; data_tbl[4] = 32'd14;
        start_frame(); wait_idle(100); sweep();

        // Long grant stall on slot 6
        for (int i = 0; i < 10; i++) data_tbl[i] = rand_word();
        gnt_stall[6] = 50;
        start_frame(); wait_idle(200); sweep();
        gnt_stall[6] = 0;

        // frame_start during a fetch, win_loss only updates at commit
        win_loss_in = 2'b01;
        for (int i = 0; i < 10; i++) data_tbl[i] = 32'(9 - i);
        start_frame();
        repeat (4) @(negedge clk);
        frame_start = 1; @(negedge clk); frame_start = 0;
        wait_idle(100); sweep();

        // Missing read data on slot 1 -> timeout, display bank retained
        for (int i = 0; i < 10; i++) data_tbl[i] = rand_word();
        drop_slot = 1;
        start_frame(); wait_idle(400);
        drop_slot = -1;
        sweep();

        // Reset during WAIT_DATA of slot 7, with a coincident frame_start
        start_frame();
        n = 0;
        while (!(m_granted && m_nxt == 7) && n < 100) begin
            @(negedge clk); n++;
        end
        check("reach_slot7", 32'(m_granted && m_nxt == 7), 32'd1);
        reset = 0; frame_start = 1;
        @(negedge clk); reset = 1; frame_start = 0;
        sweep();

        // Randomized traffic
        rand_mode = 1; spur_en = 1;
        repeat (3000) begin
            @(negedge clk);
            slot_sel = 4'($urandom_range(0, 15));
            win_loss_in = 2'($urandom_range(0, 3));
            frame_start = ($urandom_range(0, 39) == 0);
            if (!m_active) begin
                for (int i = 0; i < 10; i++) begin
                    data_tbl[i] = rand_word(); gnt_stall[i] = $urandom_range(0, 3);
                end
                drop_slot = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 9)) : -1;
            end
            reset = ($urandom_range(0, 599) != 0);
        end
        @(negedge clk); reset = 1; frame_start = 0; drop_slot = -1;
        wait_idle(600);
        sweep();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
